pkt_source_gen: RTL and testbench

PKT_SOURCE_GEN -- requirements
Module: pkt_source_gen

---
 rtl/pkt_source_gen.sv | 116 +++++++++++
 tb/tb_pkt_source_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_source_gen.sv
// pkt_source_gen: trace-replay / LFSR-random packet source with output FIFO and measurement counters
// Ports: clk/rst (async, active-high); timestamp, mode (0/3 idle, 1 trace, 2 random), rate, seed;
//        trace_wr_* loads {dest, time} entries, trace_len bounds replay; warmup/measure_len set the window;
//        net_full backpressures pkt_*; pkt_count/pkt_test/drop_count/fifo_error/trace_done report status.
module pkt_source_gen #(
    parameter int PORT_NO     = 0,
    parameter int PORTS       = 16,
    parameter int TRACE_DEPTH = 4096,
    parameter int FIFO_DEPTH  = 512,
    localparam int DW = $clog2(PORTS),
    localparam int AW = $clog2(TRACE_DEPTH),
    localparam int FW = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      timestamp,
    input  logic [1:0]       mode,
    input  logic [31:0]      rate,
    input  logic [31:0]      seed,
    input  logic             trace_wr_en,
    input  logic [AW-1:0]    trace_wr_addr,
    input  logic [24+DW-1:0] trace_wr_data,
    input  logic [AW:0]      trace_len,
    input  logic [15:0]      warmup,
    input  logic [15:0]      measure_len,
    input  logic             net_full,
    output logic             pkt_valid,
    output logic [DW-1:0]    pkt_dest,
    output logic [DW-1:0]    pkt_source,
    output logic [23:0]      pkt_data,
    output logic             pkt_measure,
    output logic [15:0]      pkt_count,
    output logic [15:0]      pkt_test,
    output logic [15:0]      drop_count,
    output logic             fifo_error,
    output logic             trace_done
);
    localparam logic [DW-1:0] SRC = DW'(PORT_NO);
    logic [24+DW-1:0] trace_mem [TRACE_DEPTH];
    logic [24+DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]      ptr_q, ptr_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [FW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [15:0]      cnt_q, cnt_d, test_q, test_d, drop_q, drop_d;
    logic             err_q, err_d;
    logic [24+DW-1:0] entry, head;
    logic [DW-1:0]    rnd_dest, gen_dest;
    logic [16:0]      win_end;
    logic             trace_on, hit, miss, rnd, gen, empty, full, pop, push, drop;
    assign entry       = trace_mem[ptr_q[AW-1:0]];
    assign head        = fifo_mem[rd_q[FW-1:0]];
    assign win_end     = {1'b0, warmup} + {1'b0, measure_len};
    assign pkt_measure = cnt_q >= warmup && {1'b0, cnt_q} < win_end;
    assign pkt_valid   = pop;
    assign pkt_dest    = head[24 +: DW];
    assign pkt_data    = head[23:0];
    assign pkt_source  = SRC;
    assign pkt_count   = cnt_q;
    assign pkt_test    = test_q;
    assign drop_count  = drop_q;
    assign fifo_error  = err_q;
    assign trace_done  = ptr_q >= trace_len;
    always_comb begin
        trace_on = mode == 2'd1 && ptr_q < trace_len && {8'd0, timestamp} < rate;
        hit      = trace_on && entry[23:0] == timestamp;
        miss     = trace_on && entry[23:0] < timestamp;
        // a random packet never targets its own source port
        rnd_dest = lfsr_q[31 -: DW] == SRC ? SRC + DW'(1) : lfsr_q[31 -: DW];
        rnd      = mode == 2'd2 && lfsr_q < rate;
        gen      = hit || rnd;
        gen_dest = hit ? entry[24 +: DW] : rnd_dest;
        empty    = wr_q == rd_q;
        full     = wr_q == {~rd_q[FW], rd_q[FW-1:0]};
        pop      = !empty && !net_full;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        push     = gen && (!full || pop);
        drop     = miss || (gen && !push);
        ptr_d    = mode != 2'd1 ? '0 : ptr_q + {{AW{1'b0}}, hit || miss};
        lfsr_d   = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        wr_d     = wr_q + {{FW{1'b0}}, push};
        rd_d     = rd_q + {{FW{1'b0}}, pop};
        cnt_d    = cnt_q + {15'd0, pop};
        test_d   = test_q + {15'd0, pop && pkt_measure};
        drop_d   = drop && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
        err_d    = err_q || (gen && !push);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            lfsr_q <= seed == 32'd0 ? 32'd1 : seed;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            test_q <= '0;
            drop_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            lfsr_q <= lfsr_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            test_q <= test_d;
            drop_q <= drop_d;
            err_q  <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (trace_wr_en)
            trace_mem[trace_wr_addr] <= trace_wr_data;
    end
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_q[FW-1:0]] <= {gen_dest, timestamp};
    end
endmodule

// File: tb/tb_pkt_source_gen.sv
// tb_pkt_source_gen: directed table and sequence checks for pkt_source_gen
module tb_pkt_source_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] timestamp;
    logic [1:0]  mode;
    logic [31:0] rate, seed;
    logic        trace_wr_en;
    logic [11:0] trace_wr_addr;
    logic [27:0] trace_wr_data;
    logic [12:0] trace_len;
    logic [15:0] warmup, measure_len;
    logic        net_full;
    logic        pkt_valid, pkt_measure, fifo_error, trace_done;
    logic [3:0]  pkt_dest, pkt_source;
    logic [23:0] pkt_data;
    logic [15:0] pkt_count, pkt_test, drop_count;

    pkt_source_gen #(.PORT_NO(0), .PORTS(16), .TRACE_DEPTH(4096), .FIFO_DEPTH(512)) dut (
        .clk(clk), .rst(rst), .timestamp(timestamp), .mode(mode), .rate(rate), .seed(seed),
        .trace_wr_en(trace_wr_en), .trace_wr_addr(trace_wr_addr), .trace_wr_data(trace_wr_data),
        .trace_len(trace_len), .warmup(warmup), .measure_len(measure_len), .net_full(net_full),
        .pkt_valid(pkt_valid), .pkt_dest(pkt_dest), .pkt_source(pkt_source), .pkt_data(pkt_data),
        .pkt_measure(pkt_measure), .pkt_count(pkt_count), .pkt_test(pkt_test),
        .drop_count(drop_count), .fifo_error(fifo_error), .trace_done(trace_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] ts;
        logic        v;
        logic [3:0]  dest;
        logic [23:0] data;
        logic [15:0] drop;
        logic        done;
    } vec_t;
    vec_t vt [21];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ml;
    logic [3:0]  q [$];
    int          mdrop;

    always @(posedge clk or posedge rst)
        if (rst) ml <= seed == 32'd0 ? 32'd1 : seed;
        else     ml <= {ml[30:0], ml[31] ^ ml[21] ^ ml[1] ^ ml[0]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic [31:0] s);
        rst = 1'b1;
        seed = s;
        mode = 2'd0;
        net_full = 1'b0;
        q.delete();
        mdrop = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one cycle of random/idle traffic checked against a queue model of the FIFO
    task automatic rcyc();
        logic ev, g, acc;
        logic [3:0] d;
        #1;
        ev = q.size() > 0 && !net_full;
        chk("rnd_valid", {31'd0, pkt_valid}, {31'd0, ev});
        if (ev) begin
            chk("rnd_dest", {28'd0, pkt_dest}, {28'd0, q[0]});
            chk("dest_not_self", {31'd0, pkt_dest != 4'd0}, 32'd1);
        end
        g = mode == 2'd2 && ml < rate;
        d = ml[31:28] == 4'd0 ? 4'd1 : ml[31:28];
        acc = g && (q.size() < 512 || ev);
        if (ev) void'(q.pop_front());
        if (acc) q.push_back(d);
        else if (g && mdrop < 16'hFFFF) mdrop++;
        @(negedge clk);
    endtask

    task automatic run_trace_table();
        for (int i = 0; i < 21; i++) begin
            timestamp = vt[i].ts;
            #1;
            chk($sformatf("trace_valid@%0d", i), {31'd0, pkt_valid}, {31'd0, vt[i].v});
            if (vt[i].v) begin
                chk($sformatf("trace_dest@%0d", i), {28'd0, pkt_dest}, {28'd0, vt[i].dest});
                chk($sformatf("trace_data@%0d", i), {8'd0, pkt_data}, {8'd0, vt[i].data});
                chk("pkt_source", {28'd0, pkt_source}, 32'd0);
            end
            chk($sformatf("trace_drop@%0d", i), {16'd0, drop_count}, {16'd0, vt[i].drop});
            chk($sformatf("trace_done@%0d", i), {31'd0, trace_done}, {31'd0, vt[i].done});
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] pat;
        int nv;
        for (int i = 0; i < 21; i++) begin
            vt[i].ts = 24'(i);
            vt[i].v = 1'b0;
            vt[i].dest = 4'd0;
            vt[i].data = 24'd0;
            vt[i].drop = i >= 9 ? 16'd1 : 16'd0;
            vt[i].done = i >= 9;
        end
        vt[6].v = 1'b1; vt[6].dest = 4'd3; vt[6].data = 24'd5;
        vt[8].v = 1'b1; vt[8].dest = 4'd1; vt[8].data = 24'd7;

        timestamp = '0; rate = '0; trace_wr_en = 1'b0; trace_wr_addr = '0; trace_wr_data = '0;
        trace_len = 13'd3; warmup = '0; measure_len = '0; mode = 2'd0; net_full = 1'b0;
        mdrop = 0;
        rst = 1'b1;
        seed = 32'hACE1_2345;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, pkt_valid}, 32'd0);
        chk("rst_count", {16'd0, pkt_count}, 32'd0);
        chk("rst_test", {16'd0, pkt_test}, 32'd0);
        chk("rst_drop", {16'd0, drop_count}, 32'd0);
        chk("rst_err", {31'd0, fifo_error}, 32'd0);
        chk("rst_done", {31'd0, trace_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        trace_wr_en = 1'b1;
        trace_wr_addr = 12'd0; trace_wr_data = {4'd3, 24'd5}; @(negedge clk);
        trace_wr_addr = 12'd1; trace_wr_data = {4'd1, 24'd7}; @(negedge clk);
        trace_wr_addr = 12'd2; trace_wr_data = {4'd2, 24'd7}; @(negedge clk);
        trace_wr_en = 1'b0;
        mode = 2'd1; rate = 32'd100;
        run_trace_table();
        mode = 2'd0;
        @(negedge clk);
        #1;
        chk("ptr_cleared_done", {31'd0, trace_done}, 32'd0);

        // reset while draining: output drops at once, LFSR restarts at seed, trace memory kept
        do_reset(32'h1234_5678);
        mode = 2'd2; rate = 32'hFFFF_FFFF; net_full = 1'b1;
        for (int i = 0; i < 10; i++) rcyc();
        mode = 2'd0; net_full = 1'b0;
        rcyc();
        rcyc();
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, pkt_valid}, 32'd0);
        chk("midrst_count", {16'd0, pkt_count}, 32'd0);
        chk("midrst_drop", {16'd0, drop_count}, 32'd0);
        chk("midrst_test", {16'd0, pkt_test}, 32'd0);
        q.delete();
        mdrop = 0;
        @(negedge clk);
        rst = 1'b0;
        mode = 2'd2;
        for (int i = 0; i < 6; i++) rcyc();
        mode = 2'd0;
        rcyc();
        rcyc();
        mode = 2'd1; rate = 32'd100;
        run_trace_table();
        mode = 2'd0;

        do_reset(32'd0);
        mode = 2'd2; rate = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) rcyc();
        mode = 2'd0;
        rcyc();
        rcyc();

        // entry beyond the stop time is never consumed
        do_reset(32'h0BAD_F00D);
        trace_wr_en = 1'b1; trace_wr_addr = 12'd0; trace_wr_data = {4'd4, 24'd50};
        @(negedge clk);
        trace_wr_en = 1'b0;
        trace_len = 13'd1; rate = 32'd40; mode = 2'd1;
        nv = 0;
        for (int t = 0; t <= 60; t++) begin
            timestamp = 24'(t);
            #1;
            if (pkt_valid) nv++;
            @(negedge clk);
        end
        chk("stop_no_pkts", nv, 0);
        chk("stop_done", {31'd0, trace_done}, 32'd0);
        chk("stop_drop", {16'd0, drop_count}, 32'd0);
        rate = 32'd100; timestamp = 24'd50;
        @(negedge clk);
        timestamp = 24'd51;
        #1;
        chk("stop_ptr0_valid", {31'd0, pkt_valid}, 32'd1);
        chk("stop_ptr0_dest", {28'd0, pkt_dest}, 32'd4);
        chk("stop_ptr0_data", {8'd0, pkt_data}, 32'd50);
        chk("stop_ptr0_done", {31'd0, trace_done}, 32'd1);
        @(negedge clk);
        mode = 2'd0;

        // measurement window
        do_reset(32'hC0FF_EE01);
        warmup = 16'd2; measure_len = 16'd3;
        mode = 2'd2; rate = 32'hFFFF_FFFF; net_full = 1'b1;
        for (int i = 0; i < 8; i++) rcyc();
        mode = 2'd0; net_full = 1'b0;
        pat = 8'b0001_1100;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("meas_valid@%0d", i), {31'd0, pkt_valid}, 32'd1);
            chk($sformatf("meas@%0d", i), {31'd0, pkt_measure}, {31'd0, pat[i]});
            @(negedge clk);
        end
        #1;
        chk("meas_count", {16'd0, pkt_count}, 32'd8);
        chk("meas_test", {16'd0, pkt_test}, 32'd3);
        chk("meas_empty", {31'd0, pkt_valid}, 32'd0);
        q.delete();
        @(negedge clk);

        // overflow under backpressure, then push accepted while full with a pop
        do_reset(32'h5EED_0001);
        warmup = 16'd0; measure_len = 16'd0;
        mode = 2'd2; rate = 32'hFFFF_FFFF; net_full = 1'b1;
        for (int i = 0; i < 600; i++) rcyc();
        #1;
        chk("ovf_err", {31'd0, fifo_error}, 32'd1);
        chk("ovf_drop", {16'd0, drop_count}, mdrop);
        net_full = 1'b0;
        rcyc();
        chk("full_pushpop_drop", {16'd0, drop_count}, mdrop);
        mode = 2'd0;
        for (int i = 0; i < 512; i++) rcyc();
        #1;
        chk("ovf_drained", {31'd0, pkt_valid}, 32'd0);
        chk("ovf_count", {16'd0, pkt_count}, 32'd513);
        chk("ovf_err_sticky", {31'd0, fifo_error}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
